sbitstream_gen: RTL and testbench

SBITSTREAM_GEN -- requirements
Module: sbitstream_gen

---
 rtl/sbitstream_gen.sv | 106 ++++++++++
 tb/tb_sbitstream_gen.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sbitstream_gen.sv
// Stochastic bitstream generator: one shared Galois LFSR, per-channel rotated compare
// words and signed-magnitude hold registers producing exclusive positive/negative streams.
module sbitstream_gen #(
  parameter int                  BITWIDTH = 20,
  parameter int                  NUM_CH   = 4,
  parameter logic [BITWIDTH-1:0] SEED     = {{(BITWIDTH-1){1'b0}}, 1'b1},
  parameter int                  ROT_STEP = 7,
  localparam int                 CHW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                en,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [CHW-1:0]      ld_ch,
  input  logic                ld_neg,
  input  logic [BITWIDTH-1:0] ld_mag,
  input  logic                seed_valid,
  input  logic [BITWIDTH-1:0] seed,
  output logic [NUM_CH-1:0]   out_p,
  output logic [NUM_CH-1:0]   out_m
);

  // Right-shifting Galois masks of primitive polynomials; zero marks an unsupported width.
  function automatic logic [63:0] tap_mask(input int w);
    case (w)
      8:       return 64'h0000_0000_0000_00B8;
      16:      return 64'h0000_0000_0000_D008;
      20:      return 64'h0000_0000_0009_0000;
      24:      return 64'h0000_0000_00E1_0000;
      32:      return 64'h0000_0000_8020_0003;
      48:      return 64'h0000_C000_0018_0000;
      64:      return 64'hD800_0000_0000_0000;
      default: return 64'h0;
    endcase
  endfunction

  function automatic logic [BITWIDTH-1:0] rotl(input logic [BITWIDTH-1:0] v, input int amt);
    logic [BITWIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < BITWIDTH; i++) begin
      r[(i + amt) % BITWIDTH] = v[i];
    end
    return r;
  endfunction

  localparam logic [63:0]         MASK64      = tap_mask(BITWIDTH);
  localparam logic [BITWIDTH-1:0] TAPS        = MASK64[BITWIDTH-1:0];
  localparam logic [BITWIDTH-1:0] ONE         = {{(BITWIDTH-1){1'b0}}, 1'b1};
  localparam logic [BITWIDTH-1:0] RESET_STATE = (SEED == '0) ? ONE : SEED;

  if (MASK64 == 64'h0) begin : g_bad_width
    $error("sbitstream_gen: unsupported BITWIDTH %0d", BITWIDTH);
  end
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("sbitstream_gen: NUM_CH %0d out of range 1..16", NUM_CH);
  end

  logic [BITWIDTH-1:0]             lfsr;
  logic [BITWIDTH-1:0]             lfsr_next;
  logic [NUM_CH-1:0]               neg;
  logic [NUM_CH-1:0][BITWIDTH-1:0] mag;
  logic [NUM_CH-1:0]               hit;
  logic                            xfer;

  assign lfsr_next = {1'b0, lfsr[BITWIDTH-1:1]} ^ (lfsr[0] ? TAPS : '0);
  assign xfer      = ld_valid && ld_ready;

  // Full-scale magnitude saturates so that it fires even on the all-ones LFSR state.
  always_comb begin
    hit = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      hit[k] = (rotl(lfsr, (k * ROT_STEP) % BITWIDTH) < mag[k]) || (&mag[k]);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      lfsr     <= RESET_STATE;
      neg      <= '0;
      mag      <= '0;
      out_p    <= '0;
      out_m    <= '0;
      ld_ready <= 1'b0;
    end else begin
      if (seed_valid) begin
        lfsr <= (seed == '0) ? ONE : seed;
      end else if (en) begin
        lfsr <= lfsr_next;
      end
      // Busy for exactly one cycle after each accepted load; out-of-range channels are dropped.
      ld_ready <= !xfer;
      if (xfer) begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (ld_ch == CHW'(k)) begin
            neg[k] <= ld_neg;
            mag[k] <= ld_mag;
          end
        end
      end
      out_p <= en ? (hit & ~neg) : '0;
      out_m <= en ? (hit & neg) : '0;
    end
  end

endmodule

// File: tb/tb_sbitstream_gen.sv
// Directed self-checking bench for sbitstream_gen at BITWIDTH=8, NUM_CH=3 (ld_ch can go out of range).
module tb_sbitstream_gen;

  logic       CLK;
  logic       nRST;
  logic       en;
  logic       ld_valid;
  logic       ld_ready;
  logic [1:0] ld_ch;
  logic       ld_neg;
  logic [7:0] ld_mag;
  logic       seed_valid;
  logic [7:0] seed;
  logic [2:0] out_p;
  logic [2:0] out_m;

  int evals = 0;
  int fails = 0;
  int cnt_p[3];
  int cnt_m[3];
  int co01, co12, co02, both;
  logic [7:0] mdl;
  logic [7:0] tb_mag[3];
  logic       tb_neg[3];

  sbitstream_gen #(.BITWIDTH(8), .NUM_CH(3)) dut (
    .CLK(CLK), .nRST(nRST), .en(en),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_ch(ld_ch), .ld_neg(ld_neg), .ld_mag(ld_mag),
    .seed_valid(seed_valid), .seed(seed),
    .out_p(out_p), .out_m(out_m)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    evals++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // x^8+x^6+x^5+x^4+1 in right-shifting Galois form.
  function automatic logic [7:0] step8(input logic [7:0] s);
    return {1'b0, s[7:1]} ^ (s[0] ? 8'hB8 : 8'h00);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] s, input int amt);
    logic [15:0] d;
    d = {s, s} << amt;
    return d[15:8];
  endfunction

  task automatic load(input logic [1:0] ch, input logic n, input logic [7:0] m);
    ld_valid = 1'b1; ld_ch = ch; ld_neg = n; ld_mag = m;
    tick();
    ld_valid = 1'b0;
    tick();
  endtask

  task automatic run_count(input int n);
    for (int k = 0; k < 3; k++) begin cnt_p[k] = 0; cnt_m[k] = 0; end
    co01 = 0; co12 = 0; co02 = 0; both = 0;
    en = 1'b1;
    for (int c = 0; c < n; c++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        cnt_p[k] += int'(out_p[k]);
        cnt_m[k] += int'(out_m[k]);
      end
      co01 += int'((out_p[0] | out_m[0]) & (out_p[1] | out_m[1]));
      co12 += int'((out_p[1] | out_m[1]) & (out_p[2] | out_m[2]));
      co02 += int'((out_p[0] | out_m[0]) & (out_p[2] | out_m[2]));
      both += int'(|(out_p & out_m));
    end
    en = 1'b0;
    tick();
  endtask

  task automatic check_model(input int n, input string tag);
    logic [2:0] ep, em;
    logic       h;
    en = 1'b1;
    for (int c = 0; c < n; c++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        h = (rotl8(mdl, (k * 7) % 8) < tb_mag[k]) || (tb_mag[k] == 8'hFF);
        ep[k] = h & ~tb_neg[k];
        em[k] = h & tb_neg[k];
      end
      check({tag, "_p"}, 32'(out_p), 32'(ep));
      check({tag, "_m"}, 32'(out_m), 32'(em));
      mdl = step8(mdl);
    end
    en = 1'b0;
    tick();
  endtask

  initial begin
    nRST = 1'b0; en = 1'b0; ld_valid = 1'b0; ld_ch = 2'd0; ld_neg = 1'b0;
    ld_mag = 8'd0; seed_valid = 1'b0; seed = 8'd0;
    repeat (2) @(negedge CLK);
    check("rst_out_p", 32'(out_p), 32'd0);
    check("rst_out_m", 32'(out_m), 32'd0);
    check("rst_ready", 32'(ld_ready), 32'd0);

    // Load requested across reset release: no transfer at the first edge.
    ld_valid = 1'b1; ld_ch = 2'd0; ld_neg = 1'b0; ld_mag = 8'hFF;
    nRST = 1'b1;
    #1 check("ready_before_edge", 32'(ld_ready), 32'd0);
    @(negedge CLK);
    check("ready_first_edge", 32'(ld_ready), 32'd1);
    tick();
    check("ready_busy", 32'(ld_ready), 32'd0);
    ld_valid = 1'b0; ld_mag = 8'h20;
    tick();
    check("ready_back", 32'(ld_ready), 32'd1);
    run_count(255);
    check("full_pos_cnt_p0", cnt_p[0], 255);
    check("full_pos_cnt_m0", cnt_m[0], 0);
    check("zero_mag_cnt_p1", cnt_p[1] + cnt_m[1], 0);

    load(2'd0, 1'b1, 8'hFF);
    run_count(255);
    check("full_neg_cnt_m0", cnt_m[0], 255);
    check("full_neg_cnt_p0", cnt_p[0], 0);

    load(2'd0, 1'b0, 8'h80);
    run_count(255);
    check("half_cnt_p0", cnt_p[0], 127);
    check("half_cnt_m0", cnt_m[0], 0);

    // Back-to-back requests: second one waits out the busy cycle with fresh data.
    ld_valid = 1'b1; ld_ch = 2'd0; ld_neg = 1'b0; ld_mag = 8'h40;
    tick();
    check("b2b_busy1", 32'(ld_ready), 32'd0);
    ld_ch = 2'd1; ld_neg = 1'b1; ld_mag = 8'hC0;
    tick();
    check("b2b_ready", 32'(ld_ready), 32'd1);
    tick();
    check("b2b_busy2", 32'(ld_ready), 32'd0);
    ld_valid = 1'b0;
    tick();
    check("b2b_idle", 32'(ld_ready), 32'd1);
    run_count(255);
    check("b2b_cnt_p0", cnt_p[0], 63);
    check("b2b_cnt_m1", cnt_m[1], 191);
    check("b2b_cnt_p1", cnt_p[1], 0);
    check("b2b_exclusive", both, 0);

    ld_valid = 1'b1; ld_ch = 2'd3; ld_neg = 1'b1; ld_mag = 8'hFF;
    tick();
    check("oor_busy", 32'(ld_ready), 32'd0);
    ld_valid = 1'b0;
    tick();
    run_count(255);
    check("oor_cnt_p0", cnt_p[0], 63);
    check("oor_cnt_m1", cnt_m[1], 191);
    check("oor_cnt_ch2", cnt_p[2] + cnt_m[2], 0);

    load(2'd0, 1'b0, 8'h80);
    load(2'd1, 1'b0, 8'h80);
    load(2'd2, 1'b0, 8'h80);
    run_count(255);
    check("dec_cnt_p0", cnt_p[0], 127);
    check("dec_cnt_p1", cnt_p[1], 127);
    check("dec_cnt_p2", cnt_p[2], 127);
    check("dec_co01", co01, 63);
    check("dec_co12", co12, 63);
    check("dec_co02", co02, 63);
    check("dec_exclusive", both, 0);

    load(2'd1, 1'b1, 8'h40);
    load(2'd2, 1'b0, 8'hC0);
    seed_valid = 1'b1; seed = 8'h00;
    tick();
    seed_valid = 1'b0;
    check("reseed_en0_out", 32'(out_p | out_m), 32'd0);
    mdl = 8'h01;
    tb_mag[0] = 8'h80; tb_neg[0] = 1'b0;
    tb_mag[1] = 8'h40; tb_neg[1] = 1'b1;
    tb_mag[2] = 8'hC0; tb_neg[2] = 1'b0;
    check_model(20, "seq_from_1");

    // Reseed and load landing on the same edge while running.
    en = 1'b1;
    seed_valid = 1'b1; seed = 8'h5A;
    ld_valid = 1'b1; ld_ch = 2'd2; ld_neg = 1'b1; ld_mag = 8'hFF;
    tick();
    seed_valid = 1'b0; ld_valid = 1'b0;
    mdl = 8'h5A; tb_mag[2] = 8'hFF; tb_neg[2] = 1'b1;
    check_model(10, "seq_reseed_load");

    en = 1'b1;
    ld_valid = 1'b1; ld_ch = 2'd0; ld_neg = 1'b0; ld_mag = 8'h10;
    tick();
    check("pre_rst_out_m2", 32'(out_m[2]), 32'd1);
    #2 nRST = 1'b0;
    #1;
    check("mid_rst_out_p", 32'(out_p), 32'd0);
    check("mid_rst_out_m", 32'(out_m), 32'd0);
    check("mid_rst_ready", 32'(ld_ready), 32'd0);
    @(negedge CLK);
    ld_valid = 1'b0; en = 1'b0;
    nRST = 1'b1;
    #1 check("post_rst_ready0", 32'(ld_ready), 32'd0);
    @(negedge CLK);
    check("post_rst_ready1", 32'(ld_ready), 32'd1);
    load(2'd0, 1'b0, 8'h80);
    mdl = 8'h01;
    tb_mag[0] = 8'h80; tb_neg[0] = 1'b0;
    tb_mag[1] = 8'h00; tb_neg[1] = 1'b0;
    tb_mag[2] = 8'h00; tb_neg[2] = 1'b0;
    check_model(12, "post_rst_seq");

    $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
    $finish;
  end

endmodule
